// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipe field scroller.
package pipe_pkg;

  typedef enum logic {GEN_SPACE, GEN_PIPE} gen_state_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Number of distinct gap_top positions (1 .. rows-gap-1).
  function automatic int gap_range(input int rows, input int gap);
    return rows - gap - 1;
  endfunction

endpackage

// File: rtl/pipe_field_scroller_if.sv
// Scroll control strobes and display/score outputs of the pipe field scroller.
interface pipe_field_scroller_if #(
  parameter int ROWS    = 16,
  parameter int COLS    = 16,
  parameter int SCORE_W = 8
);
  logic                       tick;
  logic                       run;
  logic [ROWS-1:0][COLS-1:0]  GrnPixels;
  logic [ROWS-1:0][COLS-1:0]  RedPixels;
  logic                       pass_o;
  logic [SCORE_W-1:0]         score;

  modport master (
    output tick, run,
    input  GrnPixels, RedPixels, pass_o, score
  );

  modport slave (
    input  tick, run,
    output GrnPixels, RedPixels, pass_o, score
  );
endinterface

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR that advances only when asked; source of pipe gap heights.
module pipe_lfsr
  import pipe_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       step,
  output logic [7:0] state
);

  // Shift left, feeding the tap parity back into bit 0.
  always_ff @(posedge clk) begin
    if (RST) state <= SEED;
    else if (step) state <= {state[6:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/pipe_field_scroller.sv
// Endless scrolling pipe field with random gaps and a pass/score counter.
// Optional build macro: PIPE_CAP_EN adds red caps above and below each gap.
module pipe_field_scroller
  import pipe_pkg::*;
#(
  parameter int         ROWS      = 16,
  parameter int         COLS      = 16,
  parameter int         GAP       = 4,
  parameter int         PIPE_W    = 1,
  parameter int         SPACING   = 3,
  parameter int         BIRD_COL  = 11,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input logic                  clk,
  input logic                  RST,
  pipe_field_scroller_if.slave bus
);

  localparam int GAP_RANGE = gap_range(ROWS, GAP);
  localparam int GT_W      = $clog2(ROWS) + 1;
  localparam int CNT_W     = $clog2(SPACING + PIPE_W + 1);

  if (GAP + 2 > ROWS) begin : g_chk_gap
    $error("GAP+2 must not exceed ROWS");
  end
  if (BIRD_COL >= COLS - 1) begin : g_chk_bird
    $error("BIRD_COL must be below COLS-1");
  end
  if (PIPE_W < 1) begin : g_chk_pipe_w
    $error("PIPE_W must be at least 1");
  end
  if (SPACING < 1) begin : g_chk_spacing
    $error("SPACING must be at least 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_chk_seed
    $error("LFSR_SEED must be nonzero");
  end

  logic                      adv;
  logic                      lfsr_step;
  logic [7:0]                lfsr;
  gen_state_e                state;
  logic [CNT_W-1:0]          col_cnt;
  logic [GT_W-1:0]           gap_top;
  logic [ROWS-1:0]           new_grn;
  logic                      new_end;
  logic [ROWS-1:0][COLS-1:0] grn;
  logic [COLS-1:0]           end_mark;
  logic [SCORE_W-1:0]        score;
  logic                      pass;

  pipe_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .RST   (RST),
    .step  (lfsr_step),
    .state (lfsr)
  );

  // Advance strobe, LFSR step request and the column about to enter the field.
  always_comb begin
    adv       = bus.tick & bus.run & ~RST;
    lfsr_step = adv && (state == GEN_SPACE) && (col_cnt == CNT_W'(SPACING - 1));
    new_end   = (state == GEN_PIPE) && (col_cnt == CNT_W'(PIPE_W - 1));
    new_grn   = '0;
    if (state == GEN_PIPE) begin
      for (int r = 0; r < ROWS; r++) begin
        new_grn[r] = (r < int'(gap_top)) || (r >= int'(gap_top) + GAP);
      end
    end
  end

  // Generator: alternate SPACING empty columns with PIPE_W pipe columns.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= GEN_SPACE;
      col_cnt <= '0;
      gap_top <= GT_W'(1);
    end else if (adv) begin
      case (state)
        GEN_SPACE: begin
          if (col_cnt == CNT_W'(SPACING - 1)) begin
            state   <= GEN_PIPE;
            col_cnt <= '0;
            gap_top <= GT_W'(1 + int'(lfsr) % GAP_RANGE);
          end else begin
            col_cnt <= col_cnt + CNT_W'(1);
          end
        end
        default: begin
          if (col_cnt == CNT_W'(PIPE_W - 1)) begin
            state   <= GEN_SPACE;
            col_cnt <= '0;
          end else begin
            col_cnt <= col_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Scroll the field and end markers; count pipes whose last column leaves the bird.
  always_ff @(posedge clk) begin
    if (RST) begin
      grn      <= '0;
      end_mark <= '0;
      score    <= '0;
      pass     <= 1'b0;
    end else begin
      pass <= 1'b0;
      if (adv) begin
        for (int r = 0; r < ROWS; r++) begin
          grn[r] <= {grn[r][COLS-2:0], new_grn[r]};
        end
        end_mark <= {end_mark[COLS-2:0], new_end};
        if (end_mark[BIRD_COL]) begin
          pass <= 1'b1;
          if (score != '1) score <= score + SCORE_W'(1);
        end
      end
    end
  end

`ifdef PIPE_CAP_EN
  logic [ROWS-1:0]           new_red;
  logic [ROWS-1:0][COLS-1:0] red;

  // Cap rows sit directly above and below the gap of every pipe column.
  always_comb begin
    new_red = '0;
    if (state == GEN_PIPE) begin
      for (int r = 0; r < ROWS; r++) begin
        new_red[r] = (r == int'(gap_top) - 1) || (r == int'(gap_top) + GAP);
      end
    end
  end

  // Red plane scrolls in lockstep with green so caps render orange.
  always_ff @(posedge clk) begin
    if (RST) begin
      red <= '0;
    end else if (adv) begin
      for (int r = 0; r < ROWS; r++) begin
        red[r] <= {red[r][COLS-2:0], new_red[r]};
      end
    end
  end

  assign bus.RedPixels = red;
`else
  assign bus.RedPixels = '0;
`endif

  assign bus.GrnPixels = grn;
  assign bus.score     = score;
  assign bus.pass_o    = pass;

endmodule

// File: tb/tb_pipe_field_scroller.sv
// Scoreboard bench for pipe_field_scroller: stimulus pushes expected outputs,
// a monitor pops and compares one entry per clock.
module tb_pipe_field_scroller;
  import pipe_pkg::*;

  localparam int         ROWS     = 16;
  localparam int         COLS     = 16;
  localparam int         GAP      = 4;
  localparam int         PIPE_W   = 1;
  localparam int         SPACING  = 3;
  localparam int         BIRD_COL = 11;
  localparam int         SCORE_W  = 3;
  localparam logic [7:0] SEED     = 8'hA5;
  localparam int         PERIOD   = SPACING + PIPE_W;
  localparam int         SCORE_MAX = (1 << SCORE_W) - 1;
  localparam int         NGAPS    = 1024;

  typedef logic [ROWS-1:0][COLS-1:0] field_t;
  typedef struct {
    field_t             grn;
    field_t             red;
    logic [SCORE_W-1:0] score;
    logic               pass;
  } exp_t;

  logic clk;
  logic RST;
  exp_t q[$];
  int   checks;
  int   fails;
  int   gap_tab[NGAPS];
  int   n_adv;
  int   score_m;
  logic pass_m;

  pipe_field_scroller_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) bus ();

  pipe_field_scroller #(
    .ROWS(ROWS), .COLS(COLS), .GAP(GAP), .PIPE_W(PIPE_W), .SPACING(SPACING),
    .BIRD_COL(BIRD_COL), .SCORE_W(SCORE_W), .LFSR_SEED(SEED)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Column c after n advances holds whatever was emitted on advance n-c;
  // emission k is a pipe column when it falls in the last PIPE_W slots of its period.
  function automatic field_t exp_field(input int n, input bit caps);
    field_t f = '0;
    for (int c = 0; c < COLS; c++) begin
      int k = n - c;
      if (k >= 1 && ((k - 1) % PERIOD) >= SPACING) begin
        int g = gap_tab[(k - 1) / PERIOD];
        for (int r = 0; r < ROWS; r++) begin
          f[r][c] = caps ? ((r == g - 1) || (r == g + GAP)) : ((r < g) || (r >= g + GAP));
        end
      end
    end
    return f;
  endfunction

  task automatic apply_stimulus(input logic t, input logic r, input logic rst);
    exp_t e;
    int   m;
    @(negedge clk);
    bus.tick = t;
    bus.run  = r;
    RST      = rst;
    if (rst) begin
      n_adv   = 0;
      score_m = 0;
      pass_m  = 1'b0;
    end else if (t && r) begin
      n_adv++;
      m      = n_adv - BIRD_COL - 1;
      pass_m = (m >= 1) && (m % PERIOD == 0);
      if (pass_m && score_m < SCORE_MAX) score_m++;
    end else begin
      pass_m = 1'b0;
    end
    e.grn = exp_field(n_adv, 1'b0);
`ifdef PIPE_CAP_EN
    e.red = exp_field(n_adv, 1'b1);
`else
    e.red = '0;
`endif
    e.score = SCORE_W'(score_m);
    e.pass  = pass_m;
    q.push_back(e);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (bus.GrnPixels !== e.grn) begin
      fails++;
      $display("[TB] FAIL grn: got %h want %h (adv %0d)", bus.GrnPixels, e.grn, n_adv);
    end
    checks++;
    if (bus.RedPixels !== e.red) begin
      fails++;
      $display("[TB] FAIL red: got %h want %h", bus.RedPixels, e.red);
    end
    checks++;
    if (bus.score !== e.score) begin
      fails++;
      $display("[TB] FAIL score: got %0d want %0d", bus.score, e.score);
    end
    checks++;
    if (bus.pass_o !== e.pass) begin
      fails++;
      $display("[TB] FAIL pass_o: got %b want %b", bus.pass_o, e.pass);
    end
  endtask

  // Monitor: each clock the DUT presents a new output set; compare it with the oldest expectation.
  always begin
    @(posedge clk);
    #2;
    if (q.size() > 0) check_output(q.pop_front());
  end

  initial begin
    logic [7:0] s;
    checks   = 0;
    fails    = 0;
    n_adv    = 0;
    score_m  = 0;
    pass_m   = 1'b0;
    bus.tick = 1'b0;
    bus.run  = 1'b0;
    RST      = 1'b1;
    s = SEED;
    for (int j = 0; j < NGAPS; j++) begin
      gap_tab[j] = 1 + int'(s) % (ROWS - GAP - 1);
      s = lfsr_next(s);
    end

    $display("[TB] reset");
    apply_stimulus(1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] first pipe entry");
    tick_n(7);

    $display("[TB] ticks ignored while run is low");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b0, 1'b0, 1'b0);
    end

    $display("[TB] resume and first pass");
    tick_n(12);

    $display("[TB] reset coincident with tick, pipe at column 7");
    apply_stimulus(1'b0, 1'b0, 1'b1);
    tick_n(11);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    tick_n(6);

    $display("[TB] run to score saturation");
    tick_n(60);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) apply_stimulus(1'b1, 1'b1, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      apply_stimulus(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) != 0),
                     1'($urandom_range(0, 299) == 0));
    end

    @(negedge clk);
    bus.tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
